i2s_tx: RTL and testbench

Audio output transmitter at the consumer end of the channel mixer's 16-bit signed sample stream. Accepts mixed samples through a valid/ready handshake into a small FIFO and serialises each one as a standard I2S frame: 16-bit two's-complement, MSB first, same sample on left and right. Drives the external DAC pins (SCLK, LRCLK, SDATA) from a single system clock.

---
 rtl/i2s_pkg.sv | 36 +++
 rtl/i2s_tx_sample_fifo.sv | 59 +++++
 rtl/i2s_tx.sv | 139 +++++++++++++
 tb/tb_i2s_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and slot-mapping helpers for the mixer-to-DAC audio path.
// Latency: none; this file holds declarations and pure functions only.
// Backpressure: none; the package has no handshake of its own.
package i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOTS      = 32;
  localparam int SLOT_W     = $clog2(SLOTS);
  localparam int HALF_SLOTS = SLOTS / 2;
  localparam int BIT_IDX_W  = $clog2(SAMPLE_W);

  typedef logic [SLOT_W-1:0]          slot_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Word-select level: left word in the first half of the frame.
  typedef enum logic {
    LR_LEFT  = 1'b0,
    LR_RIGHT = 1'b1
  } lr_t;

  // Word-select level for a given slot.
  function automatic lr_t slot_lr(input slot_t slot);
    return (slot >= slot_t'(HALF_SLOTS)) ? LR_RIGHT : LR_LEFT;
  endfunction

  // Data bit for slots 1..31. Left word uses bit 16-slot and right word
  // bit 32-slot; both equal (16-slot) mod 16, so a truncated subtraction
  // covers both halves. Slot 0 carries the previous sample's LSB and is
  // handled by the caller.
  function automatic logic slot_bit(input slot_t slot, input sample_t s);
    logic [BIT_IDX_W-1:0] idx;
    idx = BIT_IDX_W'(slot_t'(SAMPLE_W) - slot);
    return s[idx];
  endfunction

endpackage

// File: rtl/i2s_tx_sample_fifo.sv
// Synchronous sample FIFO with occupancy output.
// Latency: a pushed entry is visible at data_o the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
import i2s_pkg::*;

module sample_fifo #(
  parameter  int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                push_i,
  input  logic [SAMPLE_W-1:0] data_i,
  input  logic                pop_i,
  output logic [SAMPLE_W-1:0] data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [LVL_W-1:0]    level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  sample_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [LVL_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sample storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: queues mixed samples and serialises each as one stereo frame.
// Latency: a sample pushed into an empty FIFO reaches slot 1 (MSB) 2*CLK_DIV clks after the next frame boundary.
// Backpressure: sample_ready is registered !full; entries drain one per frame boundary.
import i2s_pkg::*;

module i2s_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Bit-clock divider state
  logic [DIV_W-1:0] div_q;
  logic             sclk_q;

  // Frame state and registered pin drivers
  slot_t            slot_q;
  sample_t          sample_q;
  lr_t              lrclk_q;
  logic             sdata_q;
  logic             underrun_q;
  logic             ready_q;

  // Event strobes
  logic             tick;
  logic             fall;
  logic             boundary;
  slot_t            slot_next;

  // FIFO handshake
  logic             push;
  logic             pop;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [LVL_W-1:0] level_next;

  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign fall      = tick && sclk_q;
  assign boundary  = fall && (slot_q == slot_t'(SLOTS - 1));
  assign slot_next = slot_q + 1'b1;

  // Pop uses the pre-push empty flag, so a sample arriving in the boundary
  // cycle is never bypassed straight into the frame.
  assign push = sample_valid && ready_q && !fifo_full;
  assign pop  = boundary && !fifo_empty;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  (sample_in),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Occupancy after this cycle's push/pop, used to register sample_ready.
  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + 1'b1;
      2'b01:   level_next = fifo_level - 1'b1;
      default: level_next = fifo_level;
    endcase
  end

  // Divider: wraps every CLK_DIV clks and toggles the bit clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (tick) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

  // Slot sequencing, frame loading and serial data on each falling bit clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q     <= '0;
      sample_q   <= '0;
      lrclk_q    <= LR_LEFT;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (fall) begin
        slot_q  <= slot_next;
        lrclk_q <= slot_lr(slot_next);
        if (boundary) begin
          // Slot 0 carries the outgoing sample's LSB; the sdata register
          // itself holds it, so it must be taken before sample_q reloads.
          sdata_q    <= sample_q[0];
          sample_q   <= pop ? sample_t'(fifo_dout) : sample_t'('0);
          underrun_q <= fifo_empty;
        end else begin
          sdata_q <= slot_bit(slot_next, sample_q);
        end
      end
    end
  end

  // Ready is registered from the post-update occupancy; low while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (level_next != LVL_W'(FIFO_DEPTH));
    end
  end

  assign sample_ready = ready_q;
  assign sclk         = sclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx with CLK_DIV=2, FIFO_DEPTH=4: frame-level model plus directed scenarios.
// Model advances on rising edges; all checks and stimulus happen on falling edges.
// Handshake driven by a blocking push helper that waits (bounded) for sample_ready.
module tb_i2s_tx;

  localparam int CD    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 64 * CD;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        sclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  int checks = 0;
  int fails  = 0;

  i2s_tx #(
    .CLK_DIV    (CD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          mt = 0;          // rising edges since reset released
  bit          m_rst = 1'b1;
  bit          m_started = 1'b0;
  bit          m_under = 1'b0;
  bit          m_rdy = 1'b0;
  logic [15:0] mq[$];
  logic [15:0] frames[$];        // frames[k] = sample carried by frame k

  always @(posedge clk) begin
    bit          acc;
    logic [15:0] v;
    if (reset) begin
      m_started = 1'b1;
      m_rst     = 1'b1;
      mt        = 0;
      mq.delete();
      frames.delete();
      frames.push_back(16'h0000);
      m_under   = 1'b0;
      m_rdy     = 1'b0;
    end else begin
      m_rst   = 1'b0;
      acc     = sample_valid && m_rdy;
      v       = sample_in;
      mt      = mt + 1;
      m_under = 1'b0;
      if (mt % FRAME == 0) begin
        if (mq.size() > 0) frames.push_back(mq.pop_front());
        else begin
          frames.push_back(16'h0000);
          m_under = 1'b1;
        end
      end
      if (acc) mq.push_back(v);
      m_rdy = (mq.size() < DEPTH);
    end
  end

  // Expected {sclk, lrclk, sdata, underrun, sample_ready} from time arithmetic.
  function automatic logic [4:0] expect_out();
    int          f, slot, k;
    logic        sd;
    logic [15:0] w;
    if (m_rst) return 5'b0;
    f    = mt / (2 * CD);
    slot = f % 32;
    k    = f / 32;
    sd   = 1'bx;
    if (slot == 0) begin
      if (k == 0) sd = 1'b0;
      else if (k - 1 < frames.size()) begin
        w  = frames[k-1];
        sd = w[0];
      end
    end else if (k < frames.size()) begin
      w  = frames[k];
      sd = (slot <= 16) ? w[16 - slot] : w[32 - slot];
    end
    return {1'((mt / CD) % 2), 1'(slot >= 16), sd, m_under, m_rdy};
  endfunction

  // ---------------- decoder ----------------
  bit          prev_sclk = 1'b0;
  logic [15:0] dec_sr = '0;
  logic        dec_lr = 1'b0;
  logic [15:0] dl[$];
  logic [15:0] dr[$];

  // One cycle: compare all outputs to the model, then feed the decoder.
  task automatic step();
    logic [4:0]  got, exp;
    logic [15:0] word;
    @(negedge clk);
    if (m_started) begin
      got = {sclk, lrclk, sdata, underrun, sample_ready};
      exp = expect_out();
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL pins t=%0d got=%b exp=%b (sclk,lrclk,sdata,underrun,ready)", mt, got, exp);
      end
      if (m_rst) begin
        prev_sclk = 1'b0;
        dec_sr    = '0;
        dec_lr    = 1'b0;
        dl.delete();
        dr.delete();
      end else begin
        if (sclk && !prev_sclk) begin
          if (lrclk != dec_lr) begin
            word = {dec_sr[14:0], sdata};
            if (dec_lr == 1'b0) dl.push_back(word);
            else dr.push_back(word);
          end
          dec_sr = {dec_sr[14:0], sdata};
          dec_lr = lrclk;
        end
        prev_sclk = sclk;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, mt, got, exp);
    end
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (mt < target && n < 5000) begin
      step();
      n++;
    end
    chk("wait_t", mt, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("rst_pins", {sclk, lrclk, sdata, underrun, sample_ready}, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    int n;
    n = 0;
    sample_valid = 1'b1;
    sample_in    = v;
    while (!sample_ready && n < 1000) begin
      step();
      n++;
    end
    chk("push_ready", sample_ready, 1);
    step();
    sample_valid = 1'b0;
  endtask

  logic [31:0] pat;
  int          acc_cnt;

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;

    // 1: idle after reset
    do_reset();
    wait_t(1);   chk("s1_sclk_t1", sclk, 0);  chk("s1_rdy_t1", sample_ready, 1);
    wait_t(2);   chk("s1_sclk_t2", sclk, 1);
    wait_t(4);   chk("s1_sclk_t4", sclk, 0);
    wait_t(63);  chk("s1_lr_t63", lrclk, 0);
    wait_t(64);  chk("s1_lr_t64", lrclk, 1);
    wait_t(127); chk("s1_ur_t127", underrun, 0);
    wait_t(128); chk("s1_ur_t128", underrun, 1); chk("s1_lr_t128", lrclk, 0);
    wait_t(129); chk("s1_ur_t129", underrun, 0);
    wait_t(256); chk("s1_ur_t256", underrun, 1); chk("s1_sd_t256", sdata, 0);
    wait_t(260);

    // 2: single sample 0x8001, bit-exact slot map
    do_reset();
    push(16'h8001);
    pat = 32'h4000_C000;  // slot 0 at bit 31 .. slot 31 at bit 0
    wait_t(128); chk("s2_ur_t128", underrun, 0);
    for (int s = 0; s < 32; s++) begin
      wait_t(4 * (32 + s) + 1);
      chk($sformatf("s2_slot%0d", s), sdata, pat[31 - s]);
    end
    wait_t(4 * 64 + 1); chk("s2_next_slot0", sdata, 1);
    chk("s2_ur_t257", underrun, 0);

    // 3: three samples, decoded in order
    do_reset();
    push(16'h1234);
    push(16'hFEDC);
    push(16'h7FFF);
    wait_t(128); chk("s3_ur_t128", underrun, 0);
    wait_t(256); chk("s3_ur_t256", underrun, 0);
    wait_t(384); chk("s3_ur_t384", underrun, 0);
    wait_t(512); chk("s3_ur_t512", underrun, 1);
    wait_t(520);
    chk("s3_dl_size", (dl.size() >= 4) ? 1 : 0, 1);
    chk("s3_dr_size", (dr.size() >= 4) ? 1 : 0, 1);
    if (dl.size() >= 4 && dr.size() >= 4) begin
      chk("s3_l1", dl[1], 16'h1234); chk("s3_r1", dr[1], 16'h1234);
      chk("s3_l2", dl[2], 16'hFEDC); chk("s3_r2", dr[2], 16'hFEDC);
      chk("s3_l3", dl[3], 16'h7FFF); chk("s3_r3", dr[3], 16'h7FFF);
    end

    // 4: valid held high, FIFO fills then drains one per frame
    do_reset();
    sample_valid = 1'b1;
    acc_cnt      = 0;
    while (mt < 262) begin
      sample_in = 16'hA000 + 16'(acc_cnt);
      if (sample_ready) acc_cnt++;
      if (mt == 10)  begin chk("s4_acc_t10", acc_cnt, 4);  chk("s4_rdy_t10", sample_ready, 0);  end
      if (mt == 128) chk("s4_rdy_t128", sample_ready, 1);
      if (mt == 130) begin chk("s4_acc_t130", acc_cnt, 5); chk("s4_rdy_t130", sample_ready, 0); end
      if (mt == 258) chk("s4_acc_t258", acc_cnt, 6);
      step();
    end
    sample_valid = 1'b0;

    // 5: push exactly in the boundary cycle with FIFO empty
    do_reset();
    wait_t(127);
    sample_valid = 1'b1;
    sample_in    = 16'hC003;
    step();
    sample_valid = 1'b0;
    chk("s5_ur_t128", underrun, 1);
    chk("s5_rdy_t128", sample_ready, 1);
    wait_t(133); chk("s5_f1_slot1", sdata, 0);
    wait_t(256); chk("s5_ur_t256", underrun, 0);
    wait_t(261); chk("s5_f2_slot1", sdata, 1);
    wait_t(265); chk("s5_f2_slot2", sdata, 1);
    wait_t(269); chk("s5_f2_slot3", sdata, 0);

    // 6: reset mid-frame at slot 20 with three samples queued
    do_reset();
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    wait_t(20);  chk("s6_rdy_full", sample_ready, 0);
    wait_t(209); chk("s6_lr_slot20", lrclk, 1);
    do_reset();
    wait_t(1);   chk("s6_rdy_t1", sample_ready, 1);
    wait_t(2);   chk("s6_sclk_t2", sclk, 1);
    wait_t(133); chk("s6_sd_f1", sdata, 0);
    wait_t(128 + 8);
    wait_t(256); chk("s6_ur_t256", underrun, 1);
    wait_t(260);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
